// File: rtl/noc_pkg.sv
// Shared NoC router constants and types: port/VC counts, index widths and
// the default depth of each downstream VC buffer.
package noc_pkg;

  localparam int unsigned PORT_NUM            = 5;
  localparam int unsigned VC_NUM              = 2;
  localparam int unsigned PORT_SIZE           = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned VC_SIZE             = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned DEFAULT_BUFFER_SIZE = 8;

  typedef logic [PORT_SIZE-1:0] port_t;
  typedef logic [VC_SIZE-1:0]   vc_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with an internal priority pointer; the pointer
// moves to one past the granted requester only when update_en is asserted.
module round_robin_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;

  // Requester i sits at search distance k exactly when ptr == (i - k) mod N,
  // which keeps every index a constant after unrolling.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (ptr == PW'((i + N - k) % N))) begin
          grant[i] = 1'b1;
          ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
      if (|grant) begin
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (update_en) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with per-downstream-VC credit
// counters; grants and crossbar selects are combinational from registered state.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = DEFAULT_BUFFER_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]              credit_return_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]              grant_o,
  output port_t [PORT_NUM-1:0]                          xbar_sel_o,
  output logic  [PORT_NUM-1:0]                          xbar_valid_o,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]              credit_avail_o
);

  localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);

  logic [CW-1:0] credit [PORT_NUM][VC_NUM];

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   in_gnt;
  logic  [PORT_NUM-1:0]               cand_valid;
  port_t [PORT_NUM-1:0]               cand_out;
  vc_t   [PORT_NUM-1:0]               cand_dvc;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] out_req;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] out_gnt;
  logic  [PORT_NUM-1:0]               out_any;
  logic  [PORT_NUM-1:0]               port_granted;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   dec;

  // Reset gates eligibility so every grant and valid drops immediately.
  always_comb begin
    eligible = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
          for (int unsigned c = 0; c < VC_NUM; c++) begin
            if (!rst && request_i[p][v] &&
                out_port_i[p][v] == port_t'(o) &&
                downstream_vc_i[p][v] == vc_t'(c) &&
                credit[o][c] != '0) begin
              eligible[p][v] = 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : gen_in
    round_robin_arbiter #(.N(VC_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (eligible[p]),
      .update_en (port_granted[p]),
      .grant     (in_gnt[p])
    );
  end

  always_comb begin
    cand_valid = '0;
    cand_out   = '0;
    cand_dvc   = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      cand_valid[p] = |in_gnt[p];
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (in_gnt[p][v]) begin
          cand_out[p] = out_port_i[p][v];
          cand_dvc[p] = downstream_vc_i[p][v];
        end
      end
    end
  end

  always_comb begin
    out_req = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        out_req[o][p] = cand_valid[p] && (cand_out[p] == port_t'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : gen_out
    round_robin_arbiter #(.N(PORT_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (out_req[o]),
      .update_en (out_any[o]),
      .grant     (out_gnt[o])
    );
  end

  always_comb begin
    out_any      = '0;
    port_granted = '0;
    xbar_sel_o   = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      out_any[o] = |out_gnt[o];
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (out_gnt[o][p]) begin
          port_granted[p] = 1'b1;
          xbar_sel_o[o]   = port_t'(p);
        end
      end
    end
  end

  always_comb begin
    grant_o      = '0;
    xbar_valid_o = out_any;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (port_granted[p]) begin
        grant_o[p] = in_gnt[p];
      end
    end
  end

  always_comb begin
    dec = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned c = 0; c < VC_NUM; c++) begin
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
          if (port_granted[p] && cand_out[p] == port_t'(o) && cand_dvc[p] == vc_t'(c)) begin
            dec[o][c] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    credit_avail_o = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned c = 0; c < VC_NUM; c++) begin
        credit_avail_o[o][c] = (credit[o][c] != '0);
      end
    end
  end

  // A simultaneous grant and return cancel out; a return on a full counter is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        for (int unsigned c = 0; c < VC_NUM; c++) begin
          credit[o][c] <= CW'(BUFFER_SIZE);
        end
      end
    end else begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        for (int unsigned c = 0; c < VC_NUM; c++) begin
          if (dec[o][c] && !credit_return_i[o][c]) begin
            credit[o][c] <= credit[o][c] - CW'(1);
          end else if (credit_return_i[o][c] && !dec[o][c]) begin
            assert (credit[o][c] != CW'(BUFFER_SIZE))
              else $warning("credit return on full counter, out %0d vc %0d", o, c);
            if (credit[o][c] != CW'(BUFFER_SIZE)) begin
              credit[o][c] <= credit[o][c] + CW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: a table of per-cycle vectors plus directed
// sequences for credit drain, return/grant interplay, saturation and reset.
module tb_switch_allocator;
  import noc_pkg::*;

  logic clk;
  logic rst;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              credit_return_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              grant_o;
  port_t [PORT_NUM-1:0]                          xbar_sel_o;
  logic  [PORT_NUM-1:0]                          xbar_valid_o;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              credit_avail_o;

  switch_allocator #(.BUFFER_SIZE(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .request_i       (request_i),
    .out_port_i      (out_port_i),
    .downstream_vc_i (downstream_vc_i),
    .credit_return_i (credit_return_i),
    .grant_o         (grant_o),
    .xbar_sel_o      (xbar_sel_o),
    .xbar_valid_o    (xbar_valid_o),
    .credit_avail_o  (credit_avail_o)
  );

  typedef struct {
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              req;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              op;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              exp_grant;
    logic  [PORT_NUM-1:0]                          exp_valid;
    port_t [PORT_NUM-1:0]                          exp_sel;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_req(input int r, input int p, input int v, input int o, input int c);
    vecs[r].req[p][v] = 1'b1;
    vecs[r].op[p][v]  = port_t'(o);
    vecs[r].dvc[p][v] = VC_SIZE'(c);
  endtask

  task automatic add_out(input int r, input int o, input int p);
    vecs[r].exp_valid[o] = 1'b1;
    vecs[r].exp_sel[o]   = port_t'(p);
  endtask

  task automatic clear_inputs();
    request_i       = '0;
    out_port_i      = '0;
    downstream_vc_i = '0;
    credit_return_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_credits(input string tag);
    for (int o = 0; o < PORT_NUM; o++)
      for (int c = 0; c < VC_NUM; c++)
        check($sformatf("%s credit[%0d][%0d]", tag, o, c), 64'(dut.credit[o][c]), 64'd8);
  endtask

  initial begin
    logic [PORT_NUM-1:0][VC_NUM-1:0] exp_g;

    for (int r = 0; r < NVEC; r++) begin
      vecs[r].req       = '0;
      vecs[r].op        = '0;
      vecs[r].dvc       = '0;
      vecs[r].exp_grant = '0;
      vecs[r].exp_valid = '0;
      vecs[r].exp_sel   = '0;
    end
    // rows 1-4: inputs 1 and 3 contend for out 4
    for (int r = 1; r <= 4; r++) begin
      add_req(r, 1, 0, 4, 0);
      add_req(r, 3, 0, 4, 0);
      add_out(r, 4, (r % 2 == 1) ? 1 : 3);
      vecs[r].exp_grant[(r % 2 == 1) ? 1 : 3] = 2'b01;
    end
    // rows 5-8: both VCs of input 2 to out 1
    for (int r = 5; r <= 8; r++) begin
      add_req(r, 2, 0, 1, 0);
      add_req(r, 2, 1, 1, 1);
      add_out(r, 1, 2);
      vecs[r].exp_grant[2] = (r % 2 == 1) ? 2'b01 : 2'b10;
    end
    // rows 9-10: input 0 VCs to different outputs, input 4 competes for out 3
    for (int r = 9; r <= 10; r++) begin
      add_req(r, 0, 0, 3, 0);
      add_req(r, 0, 1, 0, 0);
      add_req(r, 4, 0, 3, 1);
    end
    vecs[9].exp_grant[0] = 2'b01;
    add_out(9, 3, 0);
    vecs[10].exp_grant[0] = 2'b10;
    vecs[10].exp_grant[4] = 2'b01;
    add_out(10, 0, 0);
    add_out(10, 3, 4);
    // row 11: input 3 loses out 2 and is not retried on its VC0
    add_req(11, 1, 0, 0, 0);
    add_req(11, 1, 1, 2, 1);
    add_req(11, 3, 0, 0, 0);
    add_req(11, 3, 1, 2, 1);
    vecs[11].exp_grant[1] = 2'b10;
    add_out(11, 2, 1);

    do_reset();
    #2;
    check("reset grant", 64'(grant_o), 64'd0);
    check("reset valid", 64'(xbar_valid_o), 64'd0);
    check("reset sel", 64'(xbar_sel_o), 64'd0);
    check("reset avail", 64'(credit_avail_o), 64'h3ff);
    check_all_credits("reset");

    for (int r = 0; r < NVEC; r++) begin
      @(negedge clk);
      request_i       = vecs[r].req;
      out_port_i      = vecs[r].op;
      downstream_vc_i = vecs[r].dvc;
      #2;
      check($sformatf("row%0d grant", r), 64'(grant_o), 64'(vecs[r].exp_grant));
      check($sformatf("row%0d valid", r), 64'(xbar_valid_o), 64'(vecs[r].exp_valid));
      check($sformatf("row%0d sel", r), 64'(xbar_sel_o), 64'(vecs[r].exp_sel));
      check($sformatf("row%0d avail", r), 64'(credit_avail_o), 64'h3ff);
    end

    // drain out 2 / VC 0 from input 0 VC1
    @(negedge clk);
    do_reset();
    request_i[0][1]       = 1'b1;
    out_port_i[0][1]      = port_t'(2);
    downstream_vc_i[0][1] = '0;
    exp_g = '0;
    exp_g[0] = 2'b10;
    #2;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #2;
      end
      check($sformatf("drain%0d grant", k), 64'(grant_o), 64'(exp_g));
      check($sformatf("drain%0d sel2", k), 64'(xbar_sel_o[2]), 64'd0);
      check($sformatf("drain%0d valid", k), 64'(xbar_valid_o), 64'h04);
    end
    @(negedge clk);
    #2;
    check("empty grant", 64'(grant_o), 64'd0);
    check("empty valid", 64'(xbar_valid_o), 64'd0);
    check("empty avail20", 64'(credit_avail_o[2][0]), 64'd0);
    check("empty credit", 64'(dut.credit[2][0]), 64'd0);

    // return at zero with request pending: no grant this cycle, grant next
    @(negedge clk);
    credit_return_i[2][0] = 1'b1;
    #2;
    check("ret0 grant", 64'(grant_o), 64'd0);
    @(negedge clk);
    credit_return_i[2][0] = 1'b0;
    #2;
    check("ret1 credit", 64'(dut.credit[2][0]), 64'd1);
    check("ret1 grant", 64'(grant_o), 64'(exp_g));
    @(negedge clk);
    #2;
    check("ret2 credit", 64'(dut.credit[2][0]), 64'd0);
    check("ret2 grant", 64'(grant_o), 64'd0);

    // saturation: return on a full counter is dropped
    @(negedge clk);
    do_reset();
    credit_return_i[1][1] = 1'b1;
    @(negedge clk);
    credit_return_i[1][1] = 1'b0;
    #2;
    check("sat credit", 64'(dut.credit[1][1]), 64'd8);
    check("sat avail", 64'(credit_avail_o), 64'h3ff);

    // reset asserted in the middle of traffic
    @(negedge clk);
    request_i[1][0]  = 1'b1;
    out_port_i[1][0] = port_t'(4);
    request_i[3][0]  = 1'b1;
    out_port_i[3][0] = port_t'(4);
    exp_g = '0;
    exp_g[1] = 2'b01;
    #2;
    check("pre-rst grant", 64'(grant_o), 64'(exp_g));
    @(negedge clk);
    #2;
    check("pre-rst credit40", 64'(dut.credit[4][0]), 64'd7);
    #1;
    rst = 1'b1;
    #1;
    check("in-rst grant", 64'(grant_o), 64'd0);
    check("in-rst valid", 64'(xbar_valid_o), 64'd0);
    check("in-rst credit40", 64'(dut.credit[4][0]), 64'd8);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_all_credits("post-rst");
    check("post-rst avail", 64'(credit_avail_o), 64'h3ff);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
